// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: FSM state codes,
// requester IDs and default bus widths.
package cpu_bus_pkg;

    localparam int unsigned DEF_AW = 8;
    localparam int unsigned DEF_DW = 16;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Requester IDs, also the bit positions in the one-hot grant vector
    localparam logic [1:0] REQ_IF  = 2'd0;
    localparam logic [1:0] REQ_DU  = 2'd1;
    localparam logic [1:0] REQ_DBG = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU-side requesters, the arbiter and the memory macro.
// slave: the arbiter's view; master: the requesters' and memory's view.
interface mem_bus_arbiter_if
    import cpu_bus_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
);
    // instruction fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    // data load/store port
    logic          du_req;
    logic          du_we;
    logic [AW-1:0] du_addr;
    logic [DW-1:0] du_wdata;
    logic [DW-1:0] du_rdata;
    logic          du_ack;
    // debug/loader port
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;
    // memory side
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    // status
    logic          stall;
    logic          busy;

    modport slave (
        input  if_req, if_addr,
        input  du_req, du_we, du_addr, du_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output if_rdata, if_ack, du_rdata, du_ack, dbg_rdata, dbg_ack,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        output stall, busy
    );

    modport master (
        output if_req, if_addr,
        output du_req, du_we, du_addr, du_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  if_rdata, if_ack, du_rdata, du_ack, dbg_rdata, dbg_ack,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        input  stall, busy
    );

endinterface

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational priority select: IF > DU > DBG, with DBG promoted to the top
// when the starvation boost is active.
module bus_arb_pick
    import cpu_bus_pkg::*;
(
    input  logic       if_req_i,
    input  logic       du_req_i,
    input  logic       dbg_req_i,
    input  logic       dbg_boost_i,
    output logic [2:0] grant_o
);

    // one-hot grant, all-zero when nothing is requesting
    always_comb begin
        grant_o = '0;
        if (dbg_boost_i && dbg_req_i) grant_o[REQ_DBG] = 1'b1;
        else if (if_req_i)            grant_o[REQ_IF]  = 1'b1;
        else if (du_req_i)            grant_o[REQ_DU]  = 1'b1;
        else if (dbg_req_i)           grant_o[REQ_DBG] = 1'b1;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares a single-port memory between instruction fetch, data unit and debug.
// Each access: IDLE (arbitrate + latch) -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (ack).
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned STARVE_LIMIT = 8
)(
    input  logic              clk,
    input  logic              n_rst,
    mem_bus_arbiter_if.slave  bus
);

    localparam logic [3:0] WAIT_MAX   = 4'(WAIT_CYCLES);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [1:0]    state_q, state_d;
    logic [7:0]    starve_q, starve_d;
    logic [3:0]    cnt_q;
    logic [1:0]    id_q;
    logic          cs_q, we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q, du_rdata_q, dbg_rdata_q;
    logic [2:0]    ack_q;
    logic [2:0]    grant;

    bus_arb_pick u_pick (
        .if_req_i    (bus.if_req),
        .du_req_i    (bus.du_req),
        .dbg_req_i   (bus.dbg_req),
        .dbg_boost_i (starve_q == STARVE_MAX),
        .grant_o     (grant)
    );

    // next state and saturating starvation count for the debug port
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_IDLE:   if (|grant) state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (!bus.dbg_req) begin
            starve_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (grant[REQ_DBG])            starve_d = '0;
            else if (starve_q != STARVE_MAX) starve_d = starve_q + 8'd1;
        end
    end

    // FSM, operand latch, wait counter, rdata and ack registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            cnt_q       <= '0;
            id_q        <= REQ_IF;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            du_rdata_q  <= '0;
            dbg_rdata_q <= '0;
            ack_q       <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ack_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        cs_q  <= 1'b1;
                        cnt_q <= WAIT_MAX;
                        if (grant[REQ_IF]) begin
                            id_q    <= REQ_IF;
                            we_q    <= 1'b0;
                            addr_q  <= bus.if_addr;
                            wdata_q <= '0;
                        end else if (grant[REQ_DU]) begin
                            id_q    <= REQ_DU;
                            we_q    <= bus.du_we;
                            addr_q  <= bus.du_addr;
                            wdata_q <= bus.du_wdata;
                        end else begin
                            id_q    <= REQ_DBG;
                            we_q    <= bus.dbg_we;
                            addr_q  <= bus.dbg_addr;
                            wdata_q <= bus.dbg_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        cs_q <= 1'b0;
                        we_q <= 1'b0;
                        case (id_q)
                            REQ_IF: begin
                                ack_q[REQ_IF] <= 1'b1;
                                if (!we_q) if_rdata_q <= bus.mem_rdata;
                            end
                            REQ_DU: begin
                                ack_q[REQ_DU] <= 1'b1;
                                if (!we_q) du_rdata_q <= bus.mem_rdata;
                            end
                            default: begin
                                ack_q[REQ_DBG] <= 1'b1;
                                if (!we_q) dbg_rdata_q <= bus.mem_rdata;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_cs    = cs_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.du_rdata  = du_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.if_ack    = ack_q[REQ_IF];
    assign bus.du_ack    = ack_q[REQ_DU];
    assign bus.dbg_ack   = ack_q[REQ_DBG];
    assign bus.stall     = (bus.if_req & ~ack_q[REQ_IF]) | (bus.du_req & ~ack_q[REQ_DU]);
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (WAIT_CYCLES=1, STARVE_LIMIT=3) with a
// small behavioural memory attached to the memory side.
module tb_mem_bus_arbiter;

    logic clk;
    logic n_rst;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_bus_arbiter_if #(.AW(8), .DW(16)) bus ();

    mem_bus_arbiter #(
        .AW           (8),
        .DW           (16),
        .WAIT_CYCLES  (1),
        .STARVE_LIMIT (3)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: preloaded while in reset, written on cs&we, combinational read
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (!n_rst) begin
            mem[8'h01] <= 16'h1111;
            mem[8'h02] <= 16'h2222;
            mem[8'h03] <= 16'h3333;
            mem[8'h04] <= 16'h4444;
            mem[8'h10] <= 16'hBEEF;
            mem[8'h20] <= 16'h0000;
        end else if (bus.mem_cs && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t_if, t_du, t_dbg, n_ack, n_if;

        n_rst         = 1'b0;
        bus.if_req    = 1'b0;  bus.if_addr  = '0;
        bus.du_req    = 1'b0;  bus.du_we    = 1'b0; bus.du_addr  = '0; bus.du_wdata  = '0;
        bus.dbg_req   = 1'b0;  bus.dbg_we   = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        tick();
        tick();

        // reset state
        check_eq("rst_mem_cs",   32'(bus.mem_cs),    32'h0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr),  32'h0);
        check_eq("rst_busy",     32'(bus.busy),      32'h0);
        check_eq("rst_acks",     32'({bus.if_ack, bus.du_ack, bus.dbg_ack}), 32'h0);
        check_eq("rst_if_rdata", 32'(bus.if_rdata),  32'h0);
        n_rst = 1'b1;
        tick();

        // single IF read of 0x10, ack in cycle 3
        bus.if_req = 1'b1; bus.if_addr = 8'h10;
        #1;
        check_eq("t2_stall_c0", 32'(bus.stall), 32'h1);
        tick();
        check_eq("t2_stall_c1", 32'(bus.stall),  32'h1);
        check_eq("t2_cs_c1",    32'(bus.mem_cs), 32'h1);
        check_eq("t2_busy_c1",  32'(bus.busy),   32'h1);
        tick();
        check_eq("t2_stall_c2", 32'(bus.stall),  32'h1);
        check_eq("t2_ack_c2",   32'(bus.if_ack), 32'h0);
        tick();
        check_eq("t2_ack_c3",   32'(bus.if_ack),   32'h1);
        check_eq("t2_rdata",    32'(bus.if_rdata), 32'hBEEF);
        check_eq("t2_stall_c3", 32'(bus.stall),    32'h0);
        bus.if_req = 1'b0;
        tick();
        check_eq("t2_ack_c4",   32'(bus.if_ack), 32'h0);
        check_eq("t2_busy_c4",  32'(bus.busy),   32'h0);

        // reset mid-access aborts with no ack and clears rdata
        bus.if_req = 1'b1; bus.if_addr = 8'h01;
        tick();
        check_eq("t1_cs_before", 32'(bus.mem_cs), 32'h1);
        #2;
        n_rst = 1'b0;
        #1;
        check_eq("t1_cs_async",  32'(bus.mem_cs),   32'h0);
        check_eq("t1_busy",      32'(bus.busy),     32'h0);
        check_eq("t1_if_rdata",  32'(bus.if_rdata), 32'h0);
        bus.if_req = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.if_ack || bus.du_ack || bus.dbg_ack) n_ack++;
        end
        check_eq("t1_no_ack", 32'(n_ack), 32'h0);

        // all three requesters at once: IF, DU, DBG, acks 4 cycles apart
        bus.if_req  = 1'b1; bus.if_addr  = 8'h01;
        bus.du_req  = 1'b1; bus.du_addr  = 8'h02; bus.du_we  = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_addr = 8'h03; bus.dbg_we = 1'b0;
        t_if = -1; t_du = -1; t_dbg = -1; n_ack = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.if_ack)  begin t_if  = c; n_ack++; bus.if_req  = 1'b0; end
            if (bus.du_ack)  begin t_du  = c; n_ack++; bus.du_req  = 1'b0; end
            if (bus.dbg_ack) begin t_dbg = c; n_ack++; bus.dbg_req = 1'b0; end
        end
        check_eq("t3_if_cycle",  32'(t_if),  32'd3);
        check_eq("t3_du_cycle",  32'(t_du),  32'd7);
        check_eq("t3_dbg_cycle", 32'(t_dbg), 32'd11);
        check_eq("t3_ack_count", 32'(n_ack), 32'd3);
        check_eq("t3_if_rdata",  32'(bus.if_rdata),  32'h1111);
        check_eq("t3_du_rdata",  32'(bus.du_rdata),  32'h2222);
        check_eq("t3_dbg_rdata", 32'(bus.dbg_rdata), 32'h3333);

        // DU write 0x1234 to 0x20, then read it back
        bus.du_req = 1'b1; bus.du_we = 1'b1; bus.du_addr = 8'h20; bus.du_wdata = 16'h1234;
        #1;
        check_eq("t4_we_c0", 32'(bus.mem_we), 32'h0);
        tick();
        check_eq("t4_we_c1",   32'(bus.mem_we),   32'h1);
        check_eq("t4_addr_c1", 32'(bus.mem_addr), 32'h20);
        tick();
        check_eq("t4_we_c2", 32'(bus.mem_we), 32'h1);
        tick();
        check_eq("t4_we_c3",       32'(bus.mem_we),   32'h0);
        check_eq("t4_wr_ack",      32'(bus.du_ack),   32'h1);
        check_eq("t4_rdata_keep",  32'(bus.du_rdata), 32'h2222);
        check_eq("t4_mem_written", 32'(mem[8'h20]),   32'h1234);
        bus.du_req = 1'b0; bus.du_we = 1'b0;
        tick();
        bus.du_req = 1'b1;
        n_ack = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.mem_we) n_ack++;
            if (bus.du_ack) begin bus.du_req = 1'b0; break; end
        end
        check_eq("t4_rd_no_we",  32'(n_ack),         32'h0);
        check_eq("t4_du_rdata",  32'(bus.du_rdata),  32'h1234);
        check_eq("t4_if_keep",   32'(bus.if_rdata),  32'h1111);
        check_eq("t4_dbg_keep",  32'(bus.dbg_rdata), 32'h3333);
        tick();

        // starvation: IF held high, DBG served after 3 IF accesses
        bus.if_req  = 1'b1; bus.if_addr  = 8'h10;
        bus.dbg_req = 1'b1; bus.dbg_addr = 8'h04; bus.dbg_we = 1'b0;
        n_if = 0; t_dbg = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.if_ack) begin
                n_if++;
                if (n_if == 3) check_eq("t5_starve_sat", 32'(dut.starve_q), 32'd3);
            end
            if (bus.dbg_ack) begin
                t_dbg = c;
                check_eq("t5_starve_clr", 32'(dut.starve_q), 32'd0);
                bus.dbg_req = 1'b0;
                bus.if_req  = 1'b0;
                break;
            end
        end
        check_eq("t5_if_before", 32'(n_if),          32'd3);
        check_eq("t5_dbg_cycle", 32'(t_dbg),         32'd15);
        check_eq("t5_dbg_rdata", 32'(bus.dbg_rdata), 32'h4444);
        tick();

        // DU drops req and moves addr mid-access; latched addr is used
        bus.du_req = 1'b1; bus.du_we = 1'b0; bus.du_addr = 8'h03;
        tick();
        bus.du_req = 1'b0; bus.du_addr = 8'h20;
        check_eq("t6_addr_c1", 32'(bus.mem_addr), 32'h03);
        tick();
        check_eq("t6_addr_c2", 32'(bus.mem_addr), 32'h03);
        tick();
        check_eq("t6_ack",      32'(bus.du_ack),   32'h1);
        check_eq("t6_du_rdata", 32'(bus.du_rdata), 32'h3333);
        tick();
        check_eq("t6_ack_gone", 32'(bus.du_ack), 32'h0);
        check_eq("t6_idle",     32'(bus.busy),   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
